// File: rtl/fifo_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ptr_ctrl
//   Read/write pointer, occupancy and status controller for one FIFO.
//   MEM_SIZE may be any depth from 2 to 2^PTR, including depths that are
//   not a power of two.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   reset        : asynchronous reset, active low
//   fifo_wr      : write request
//   fifo_rd      : read request
//   err_clr      : synchronous clear of the sticky error flags
//   push / pop   : memory write / read strobes (combinational)
//   wr_ptr       : write address
//   rd_ptr       : read address
//   count        : occupancy, 0..MEM_SIZE
//   fifo_empty   : count == 0
//   fifo_full    : count == MEM_SIZE
//   almost_empty : count <= ALMOST_EMPTY
//   almost_full  : count >= ALMOST_FULL
//   overflow     : sticky, a write was refused
//   underflow    : sticky, a read was refused
// ---------------------------------------------------------------------------
module fifo_ptr_ctrl #(
    parameter int MEM_SIZE     = 8,
    parameter int PTR          = 3,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           fifo_wr,
    input  logic           fifo_rd,
    input  logic           err_clr,
    output logic           push,
    output logic           pop,
    output logic [PTR-1:0] wr_ptr,
    output logic [PTR-1:0] rd_ptr,
    output logic [PTR:0]   count,
    output logic           fifo_empty,
    output logic           fifo_full,
    output logic           almost_empty,
    output logic           almost_full,
    output logic           overflow,
    output logic           underflow
);

    localparam logic [PTR-1:0] PtrLast     = PTR'(MEM_SIZE - 1);
    localparam logic [PTR:0]   MemSizeC    = (PTR+1)'(MEM_SIZE);
    localparam logic [PTR:0]   AlmostFullC = (PTR+1)'(ALMOST_FULL);
    localparam logic [PTR:0]   AlmostEmptC = (PTR+1)'(ALMOST_EMPTY);

    logic [PTR-1:0] wrPtr_q, wrPtr_d;
    logic [PTR-1:0] rdPtr_q, rdPtr_d;
    logic [PTR:0]   count_q, count_d;
    logic           overflow_q, overflow_d;
    logic           underflow_q, underflow_d;

    // Status flags decode the registered count only.
    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == MemSizeC);
    assign almost_empty = (count_q <= AlmostEmptC);
    assign almost_full  = (count_q >= AlmostFullC);

    // A read on empty is refused even with a concurrent write (no bypass);
    // a write on full is accepted only when a read frees a slot this cycle.
    assign pop  = reset & fifo_rd & ~fifo_empty;
    assign push = reset & fifo_wr & (~fifo_full | pop);

    // Next-state logic: pointers wrap at MEM_SIZE-1 so codes >= MEM_SIZE
    // never appear; errors set on refusal and set wins over err_clr.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        overflow_d  = (overflow_q  & ~err_clr) | (fifo_wr & ~push);
        underflow_d = (underflow_q & ~err_clr) | (fifo_rd & ~pop);
        if (push) begin
            wrPtr_d = (wrPtr_q == PtrLast) ? '0 : wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = (rdPtr_q == PtrLast) ? '0 : rdPtr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign wr_ptr    = wrPtr_q;
    assign rd_ptr    = rdPtr_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_ptr_ctrl
//   Drives two controllers from shared requests: instance A is 8 deep
//   (thresholds 6/2), instance B is 6 deep (thresholds 4/1), exercising the
//   non-power-of-two wrap. A behavioural occupancy model per instance is
//   compared on every falling edge, and literal expectations pin key points.
// ---------------------------------------------------------------------------
module tb_fifo_ptr_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic fifo_wr = 1'b0;
    logic fifo_rd = 1'b0;
    logic err_clr = 1'b0;

    logic       aPush, aPop, aEmpty, aFull, aAe, aAf, aOv, aUn;
    logic [2:0] aWp, aRp;
    logic [3:0] aCnt;
    logic       bPush, bPop, bEmpty, bFull, bAe, bAf, bOv, bUn;
    logic [2:0] bWp, bRp;
    logic [3:0] bCnt;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    fifo_ptr_ctrl #(.MEM_SIZE(8), .PTR(3), .ALMOST_FULL(6), .ALMOST_EMPTY(2)) dutA (
        .clk(clk), .reset(reset), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .err_clr(err_clr),
        .push(aPush), .pop(aPop), .wr_ptr(aWp), .rd_ptr(aRp), .count(aCnt),
        .fifo_empty(aEmpty), .fifo_full(aFull), .almost_empty(aAe), .almost_full(aAf),
        .overflow(aOv), .underflow(aUn));

    fifo_ptr_ctrl #(.MEM_SIZE(6), .PTR(3), .ALMOST_FULL(4), .ALMOST_EMPTY(1)) dutB (
        .clk(clk), .reset(reset), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .err_clr(err_clr),
        .push(bPush), .pop(bPop), .wr_ptr(bWp), .rd_ptr(bRp), .count(bCnt),
        .fifo_empty(bEmpty), .fifo_full(bFull), .almost_empty(bAe), .almost_full(bAf),
        .overflow(bOv), .underflow(bUn));

    // Behavioural model: occupancy as a plain integer, pointers as modulo
    // counters, errors as booleans.
    typedef struct {
        int cnt;
        int wp;
        int rp;
        bit ov;
        bit un;
    } mdl_t;

    mdl_t ma, mb;

    function automatic bit popExp(mdl_t m);
        return reset && fifo_rd && (m.cnt > 0);
    endfunction

    function automatic bit pushExp(mdl_t m, int size);
        return reset && fifo_wr && ((m.cnt < size) || popExp(m));
    endfunction

    function automatic mdl_t advance(mdl_t m, int size);
        mdl_t n = m;
        bit p = pushExp(m, size);
        bit q = popExp(m);
        if (p) n.wp = (m.wp + 1) % size;
        if (q) n.rp = (m.rp + 1) % size;
        n.cnt = m.cnt + (p ? 1 : 0) - (q ? 1 : 0);
        n.ov = (fifo_wr && !p) ? 1'b1 : (err_clr ? 1'b0 : m.ov);
        n.un = (fifo_rd && !q) ? 1'b1 : (err_clr ? 1'b0 : m.un);
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ma = '{0, 0, 0, 1'b0, 1'b0};
            mb = '{0, 0, 0, 1'b0, 1'b0};
        end else begin
            ma = advance(ma, 8);
            mb = advance(mb, 6);
        end
    end

    task automatic checkOutput(string name, int actual, int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    task automatic checkInst(string t, mdl_t m, int size, int af, int ae,
                             logic ps, logic pp, logic [2:0] wp, logic [2:0] rp,
                             logic [3:0] cnt, logic em, logic fu, logic aem,
                             logic afu, logic ov, logic un);
        checkOutput({t, ".push"}, int'(ps), int'(pushExp(m, size)));
        checkOutput({t, ".pop"}, int'(pp), int'(popExp(m)));
        checkOutput({t, ".wr_ptr"}, int'(wp), m.wp);
        checkOutput({t, ".rd_ptr"}, int'(rp), m.rp);
        checkOutput({t, ".count"}, int'(cnt), m.cnt);
        checkOutput({t, ".empty"}, int'(em), int'(m.cnt == 0));
        checkOutput({t, ".full"}, int'(fu), int'(m.cnt == size));
        checkOutput({t, ".almost_empty"}, int'(aem), int'(m.cnt <= ae));
        checkOutput({t, ".almost_full"}, int'(afu), int'(m.cnt >= af));
        checkOutput({t, ".overflow"}, int'(ov), int'(m.ov));
        checkOutput({t, ".underflow"}, int'(un), int'(m.un));
    endtask

    // Model comparison on every falling edge, away from the active edge.
    always @(negedge clk) begin
        checkInst("A", ma, 8, 6, 2, aPush, aPop, aWp, aRp, aCnt, aEmpty, aFull, aAe, aAf, aOv, aUn);
        checkInst("B", mb, 6, 4, 1, bPush, bPop, bWp, bRp, bCnt, bEmpty, bFull, bAe, bAf, bOv, bUn);
    end

    // Drive requests for one cycle; returns 1 time unit after the edge.
    task automatic applyStimulus(bit wr, bit rd, bit clr);
        fifo_wr = wr;
        fifo_rd = rd;
        err_clr = clr;
        @(posedge clk);
        #1;
        fifo_wr = 1'b0;
        fifo_rd = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        checkOutput("rst.count", int'(aCnt), 0);
        checkOutput("rst.empty", int'(aEmpty), 1);
        checkOutput("rst.almost_empty", int'(aAe), 1);
        checkOutput("rst.full", int'(aFull), 0);
        checkOutput("rst.almost_full", int'(aAf), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset mid-operation at count 5
        repeat (5) applyStimulus(1, 0, 0);
        checkOutput("mid.count_before", int'(aCnt), 5);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("mid.count", int'(aCnt), 0);
        checkOutput("mid.wr_ptr", int'(aWp), 0);
        checkOutput("mid.empty", int'(aEmpty), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1, 0, 0);
        checkOutput("mid.wr_ptr_after", int'(aWp), 1);
        checkOutput("mid.count_after", int'(aCnt), 1);

        // Fill and wrap
        pulseReset();
        repeat (6) applyStimulus(1, 0, 0);
        checkOutput("B.fill.full", int'(bFull), 1);
        checkOutput("B.fill.count", int'(bCnt), 6);
        checkOutput("B.fill.wr_ptr", int'(bWp), 0);
        checkOutput("A.fill.almost_full", int'(aAf), 1);
        fifo_wr = 1'b1;
        #1;
        checkOutput("B.ovf.push", int'(bPush), 0);
        applyStimulus(1, 0, 0);
        checkOutput("B.ovf.overflow", int'(bOv), 1);
        checkOutput("B.ovf.count", int'(bCnt), 6);
        checkOutput("A.seven.count", int'(aCnt), 7);
        applyStimulus(1, 0, 0);
        checkOutput("A.full", int'(aFull), 1);

        // Simultaneous read/write while full
        fifo_wr = 1'b1;
        fifo_rd = 1'b1;
        #1;
        checkOutput("A.both.push", int'(aPush), 1);
        checkOutput("A.both.pop", int'(aPop), 1);
        applyStimulus(1, 1, 0);
        checkOutput("A.both.count", int'(aCnt), 8);
        checkOutput("A.both.wr_ptr", int'(aWp), 1);
        checkOutput("A.both.rd_ptr", int'(aRp), 1);
        checkOutput("A.both.overflow", int'(aOv), 0);

        // err_clr alone
        applyStimulus(0, 0, 1);
        checkOutput("B.clr.overflow", int'(bOv), 0);

        // Drain with threshold checks
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 1, 0);
            if (k == 2) checkOutput("A.af.at6", int'(aAf), 1);
            if (k == 3) checkOutput("A.af.at5", int'(aAf), 0);
            if (k == 5) checkOutput("A.ae.at3", int'(aAe), 0);
            if (k == 6) checkOutput("A.ae.at2", int'(aAe), 1);
            if (k == 6) checkOutput("B.drain.rd_ptr", int'(bRp), 1);
            if (k == 6) checkOutput("B.drain.empty", int'(bEmpty), 1);
        end
        checkOutput("B.underflow", int'(bUn), 1);
        checkOutput("A.drain.empty", int'(aEmpty), 1);

        // Read and write on empty
        fifo_wr = 1'b1;
        fifo_rd = 1'b1;
        #1;
        checkOutput("A.empty_rw.pop", int'(aPop), 0);
        checkOutput("A.empty_rw.push", int'(aPush), 1);
        applyStimulus(1, 1, 0);
        checkOutput("A.empty_rw.underflow", int'(aUn), 1);
        checkOutput("A.empty_rw.count", int'(aCnt), 1);
        checkOutput("A.empty_rw.empty", int'(aEmpty), 0);

        // Set wins over clear
        applyStimulus(0, 1, 0);
        applyStimulus(0, 0, 1);
        checkOutput("A.clr.underflow", int'(aUn), 0);
        applyStimulus(0, 1, 1);
        checkOutput("A.setwins.underflow", int'(aUn), 1);

        // Mixed traffic checked by the model, with one reset mid-burst
        for (int i = 0; i < 300; i++) begin
            if (i == 150) pulseReset();
            applyStimulus(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                          ($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
